// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM-client definitions: transaction state encoding and an index-width helper.
package jtframe_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } sdram_st_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_sdram_mux_if.sv
// Client-slot and SDRAM-controller signals of the multi-slot SDRAM mux.
interface jtframe_sdram_mux_if #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 22,
  parameter int unsigned DW    = 32
);
  logic [SLOTS-1:0]    slot_req;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS*DW-1:0] slot_data;
  logic [SLOTS-1:0]    slot_ok;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack;
  logic [DW-1:0]       data_read;
  logic                data_rdy;

  modport slave (
    input  slot_req, slot_addr, sdram_ack, data_read, data_rdy,
    output slot_data, slot_ok, sdram_req, sdram_addr
  );

  modport master (
    output slot_req, slot_addr, sdram_ack, data_read, data_rdy,
    input  slot_data, slot_ok, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtframe_rr_arbiter.sv
// Combinational round-robin arbiter: slot last_grant+1 (mod SLOTS) has highest priority.
module jtframe_rr_arbiter
  import jtframe_sdram_pkg::*;
#(
  parameter  int unsigned SLOTS = 4,
  localparam int unsigned IW    = idx_w(SLOTS)
) (
  input  logic [SLOTS-1:0] cand,
  input  logic [IW-1:0]    last_grant,
  output logic [SLOTS-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  logic          found;
  logic [IW-1:0] cur;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cur     = '0;
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      cur = IW'((32'(last_grant) + k) % SLOTS);
      if (!found && cand[cur]) begin
        found    = 1'b1;
        gnt_idx  = cur;
        gnt[cur] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_mux.sv
// N-slot front end for the single SDRAM port: round-robin grants, per-slot one-entry read cache.
module jtframe_sdram_mux
  import jtframe_sdram_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 22,
  parameter int unsigned DW    = 32
) (
  input logic               clk_rom,
  input logic               rst,
  input logic               downloading,
  input logic               loop_rst,
  jtframe_sdram_mux_if.slave bus
);

  localparam int unsigned IW = idx_w(SLOTS);

  sdram_st_e        state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic             sdram_req_q, sdram_req_d;
  logic [AW-1:0]    sdram_addr_q, sdram_addr_d;
  logic [DW-1:0]    data_q [SLOTS];
  logic [DW-1:0]    data_d [SLOTS];
  logic [AW-1:0]    cached_q [SLOTS];
  logic [AW-1:0]    cached_d [SLOTS];
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [SLOTS-1:0] ok_q, ok_d;

  logic [AW-1:0]    addr_a [SLOTS];
  logic [SLOTS-1:0] hit, cand, arb_gnt;
  logic [IW-1:0]    arb_idx;

  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      addr_a[i] = bus.slot_addr[i*AW +: AW];
      hit[i]    = valid_q[i] && (addr_a[i] == cached_q[i]);
      cand[i]   = bus.slot_req[i] && !hit[i];
    end
  end

  jtframe_rr_arbiter #(.SLOTS(SLOTS)) u_arb (
    .cand       (cand),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    data_d       = data_q;
    cached_d     = cached_q;
    valid_d      = downloading ? '0 : valid_q;
    ok_d         = bus.slot_req & hit & {SLOTS{!downloading}};

    unique case (state_q)
      IDLE: begin
        if (|arb_gnt && !downloading && !loop_rst) begin
          grant_d      = arb_idx;
          sdram_addr_d = addr_a[arb_idx];
          sdram_req_d  = 1'b1;
          state_d      = REQ;
        end
      end
      REQ, WAIT: begin
        if (loop_rst) begin
          sdram_req_d = 1'b0;
          valid_d     = '0;
          state_d     = IDLE;
        end else begin
          if (state_q == REQ && bus.sdram_ack) begin
            sdram_req_d = 1'b0;
            state_d     = WAIT;
          end
          // An ack coinciding with data_rdy completes the transaction in one step
          if ((state_q == WAIT || bus.sdram_ack) && bus.data_rdy) begin
            data_d[grant_q]   = bus.data_read;
            cached_d[grant_q] = sdram_addr_q;
            if (!downloading) valid_d[grant_q] = 1'b1;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(SLOTS-1);
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      valid_q      <= '0;
      ok_q         <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        data_q[i]   <= '0;
        cached_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      valid_q      <= valid_d;
      ok_q         <= ok_d;
      data_q       <= data_d;
      cached_q     <= cached_d;
    end
  end

  always_comb begin
    bus.slot_data = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      bus.slot_data[i*DW +: DW] = data_q[i];
    end
  end

  assign bus.slot_ok    = ok_q;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtframe_sdram_mux.sv
// Directed bench for jtframe_sdram_mux: miss/hit, round robin, ack+data, loop_rst, download, async reset.
module tb_jtframe_sdram_mux;

  localparam int unsigned SLOTS = 4;
  localparam int unsigned AW    = 22;
  localparam int unsigned DW    = 32;

  logic clk_rom = 1'b0;
  logic rst, downloading, loop_rst;

  always #5 clk_rom = ~clk_rom;

  jtframe_sdram_mux_if #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) bus ();

  jtframe_sdram_mux #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk_rom     (clk_rom),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .bus         (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk_rom);
    #1;
  endtask

  task automatic wait_req(input string tag);
    for (int unsigned c = 0; c < 20 && !bus.sdram_req; c++) step(1);
    check({tag, "_req_seen"}, 64'(bus.sdram_req), 64'd1);
  endtask

  task automatic set_addr(input int unsigned i, input logic [AW-1:0] a);
    bus.slot_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] sdata(input int unsigned i);
    return bus.slot_data[i*DW +: DW];
  endfunction

  // ack on one cycle, data on the next
  task automatic serve(input logic [DW-1:0] d);
    bus.sdram_ack = 1'b1;
    step(1);
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b1;
    bus.data_read = d;
    step(1);
    bus.data_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  int unsigned    exp_order [5] = '{0, 1, 2, 3, 0};
  logic [AW-1:0]  a_cur [SLOTS];
  localparam logic [AW-1:0] ADDR_A = 22'h02AAAA;
  localparam logic [AW-1:0] ADDR_B = 22'h03BBBB;
  localparam logic [AW-1:0] ADDR_C = 22'h0CCCC0;

  initial begin
    rst           = 1'b1;
    downloading   = 1'b0;
    loop_rst      = 1'b0;
    bus.slot_req  = '0;
    bus.slot_addr = '0;
    bus.sdram_ack = 1'b0;
    bus.data_read = '0;
    bus.data_rdy  = 1'b0;

    // 1: reset state, single miss, then repeat-address hit
    do_reset();
    check("rst_sdram_req", 64'(bus.sdram_req), 0);
    check("rst_sdram_addr", 64'(bus.sdram_addr), 0);
    check("rst_slot_ok", 64'(bus.slot_ok), 0);
    check("rst_slot_data", 64'(|bus.slot_data), 0);

    set_addr(1, 22'h000100);
    bus.slot_req = 4'b0010;
    step(1);
    check("t1_req", 64'(bus.sdram_req), 1);
    check("t1_addr", 64'(bus.sdram_addr), 64'h100);
    step(2);
    bus.sdram_ack = 1'b1;
    step(1);
    bus.sdram_ack = 1'b0;
    check("t1_req_drop", 64'(bus.sdram_req), 0);
    step(1);
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'hDEADBEEF;
    step(1);
    bus.data_rdy  = 1'b0;
    check("t1_data", 64'(sdata(1)), 64'hDEADBEEF);
    check("t1_ok_early", 64'(bus.slot_ok[1]), 0);
    step(1);
    check("t1_ok", 64'(bus.slot_ok[1]), 1);
    check("t1_no_refetch", 64'(bus.sdram_req), 0);
    bus.slot_req = 4'b0000;
    step(1);
    check("t1_ok_drop", 64'(bus.slot_ok[1]), 0);
    bus.slot_req = 4'b0010;
    step(1);
    check("t1_hit_ok", 64'(bus.slot_ok[1]), 1);
    check("t1_hit_noreq", 64'(bus.sdram_req), 0);
    bus.slot_req = 4'b0000;

    // 2: round robin with every slot missing continuously
    do_reset();
    for (int unsigned i = 0; i < SLOTS; i++) begin
      a_cur[i] = AW'(22'h001000 + i * 22'h10);
      set_addr(i, a_cur[i]);
    end
    bus.slot_req = 4'b1111;
    for (int unsigned r = 0; r < 5; r++) begin
      int unsigned s;
      s = exp_order[r];
      wait_req($sformatf("rr%0d", r));
      check($sformatf("rr%0d_addr", r), 64'(bus.sdram_addr), 64'(a_cur[s]));
      serve(32'hA000_0000 + r);
      check($sformatf("rr%0d_data", r), 64'(sdata(s)), 64'(32'hA000_0000 + r));
      a_cur[s] = a_cur[s] + 22'h400;
      set_addr(s, a_cur[s]);
    end
    bus.slot_req = 4'b0000;

    // 3: ack and data_rdy in the same cycle
    set_addr(2, ADDR_A);
    set_addr(3, ADDR_B);
    bus.slot_req = 4'b1100;
    wait_req("t3");
    check("t3_addr_a", 64'(bus.sdram_addr), 64'(ADDR_A));
    bus.sdram_ack = 1'b1;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'h3333_0002;
    step(1);
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    check("t3_idle_req", 64'(bus.sdram_req), 0);
    check("t3_data2", 64'(sdata(2)), 64'h3333_0002);
    step(1);
    check("t3_next_req", 64'(bus.sdram_req), 1);
    check("t3_addr_b", 64'(bus.sdram_addr), 64'(ADDR_B));
    check("t3_ok2", 64'(bus.slot_ok[2]), 1);
    serve(32'h3333_0003);
    step(1);
    check("t3_ok3", 64'(bus.slot_ok[3]), 1);
    bus.slot_req = 4'b0000;

    // 4: loop_rst in WAIT, then spurious data_rdy in IDLE
    set_addr(0, ADDR_C);
    bus.slot_req = 4'b0001;
    wait_req("t4");
    check("t4_addr", 64'(bus.sdram_addr), 64'(ADDR_C));
    bus.sdram_ack = 1'b1;
    step(1);
    bus.sdram_ack = 1'b0;
    loop_rst     = 1'b1;
    bus.slot_req = 4'b0000;
    step(1);
    loop_rst = 1'b0;
    check("t4_abort_req", 64'(bus.sdram_req), 0);
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'h5555_5555;
    step(1);
    bus.data_rdy = 1'b0;
    check("t4_spurious_data", 64'(sdata(0)), 64'hA000_0004);
    check("t4_spurious_req", 64'(bus.sdram_req), 0);
    bus.slot_req = 4'b0001;
    step(1);
    check("t4_refetch", 64'(bus.sdram_req), 1);
    check("t4_ok0_low", 64'(bus.slot_ok[0]), 0);
    serve(32'h4444_0000);
    step(1);
    check("t4_ok0", 64'(bus.slot_ok[0]), 1);
    bus.slot_req = 4'b0100;
    step(1);
    check("t4_slot2_miss", 64'(bus.sdram_req), 1);
    check("t4_slot2_addr", 64'(bus.sdram_addr), 64'(ADDR_A));
    check("t4_slot2_ok_low", 64'(bus.slot_ok[2]), 0);
    serve(32'h2222_0004);
    step(1);
    check("t4_slot2_ok", 64'(bus.slot_ok[2]), 1);

    // 5: downloading invalidates and blocks grants
    downloading = 1'b1;
    step(1);
    check("t5_ok2_forced", 64'(bus.slot_ok[2]), 0);
    for (int unsigned c = 0; c < 3; c++) begin
      step(1);
      check($sformatf("t5_blocked%0d", c), 64'(bus.sdram_req), 0);
    end
    downloading = 1'b0;
    step(1);
    check("t5_refetch", 64'(bus.sdram_req), 1);
    check("t5_addr", 64'(bus.sdram_addr), 64'(ADDR_A));
    serve(32'h2222_0005);
    step(1);
    check("t5_ok2", 64'(bus.slot_ok[2]), 1);
    check("t5_data2", 64'(sdata(2)), 64'h2222_0005);
    bus.slot_req = 4'b0000;

    // 6: asynchronous reset between clock edges while in REQ
    set_addr(1, 22'h011111);
    bus.slot_req = 4'b0010;
    wait_req("t6");
    #3;
    rst = 1'b1;
    #1;
    check("t6_req", 64'(bus.sdram_req), 0);
    check("t6_addr", 64'(bus.sdram_addr), 0);
    check("t6_ok", 64'(bus.slot_ok), 0);
    check("t6_data", 64'(|bus.slot_data), 0);
    rst = 1'b0;
    @(posedge clk_rom);
    #1;
    check("t6_idle_grant", 64'(bus.sdram_req), 1);
    check("t6_idle_addr", 64'(bus.sdram_addr), 64'h011111);
    bus.slot_req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
